// File: rtl/sync_fifo_param_pkg.sv
// Shared definitions for the parametrised synchronous FIFO: read-mode constants
// and constant functions used when sizing pointers and checking parameters.
package sync_fifo_param_pkg;

  localparam int MODE_STD  = 0;
  localparam int MODE_FWFT = 1;

  function automatic int clog2(input int value);
    int n;
    n = 0;
    for (int v = value - 1; v > 0; v = v >> 1) n++;
    return n;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Storage array for sync_fifo_param: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module sync_fifo_ram
  import sync_fifo_param_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [clog2(DEPTH)-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [clog2(DEPTH)-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]     rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with programmable size, thresholds and standard or
// first-word-fall-through read mode; all status outputs are registered.
module sync_fifo_param
  import sync_fifo_param_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = 14,
  parameter int AE_THRESH  = 2,
  parameter int FWFT       = MODE_STD
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic                    flush,
  input  logic                    clr_err,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   din,
  input  logic                    rd_en,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [clog2(DEPTH):0]   count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);
  localparam logic [AW:0] AF_C = (AW+1)'(AF_THRESH);
  localparam logic [AW:0] AE_C = (AW+1)'(AE_THRESH);

  // Elaboration-time legality checks; these do not produce hardware.
  if (DATA_WIDTH < 1) begin : g_bad_width
    $error("sync_fifo_param: DATA_WIDTH must be >= 1");
  end
  if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two >= 4");
  end
  if (!(AE_THRESH >= 1 && AE_THRESH < AF_THRESH && AF_THRESH <= DEPTH - 1)) begin : g_bad_thresh
    $error("sync_fifo_param: need 1 <= AE_THRESH < AF_THRESH <= DEPTH-1");
  end

  logic [AW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic                  full_q, full_d, empty_q, empty_d;
  logic                  af_q, af_d, ae_q, ae_d;
  logic                  overflow_q, overflow_d, underflow_q, underflow_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] ram_rdata;

  always_comb begin
    wr_acc   = wr_en & ~full_q & ~flush;
    rd_acc   = rd_en & ~empty_q & ~flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + ONE;
      if (rd_acc) rd_ptr_d = rd_ptr_q + ONE;
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + ONE;
        2'b01:   count_d = count_q - ONE;
        default: count_d = count_q;
      endcase
    end
    if (rd_acc) dout_d = ram_rdata;
    // Equal addresses with differing wrap bits means the array is full.
    full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    empty_d = (wr_ptr_d == rd_ptr_d);
    af_d    = (count_d >= AF_C);
    ae_d    = (count_d <= AE_C);
    // A fresh error event outranks clr_err in the same cycle.
    overflow_d  = (wr_en & full_q & ~flush)  | (overflow_q  & ~clr_err);
    underflow_d = (rd_en & empty_q & ~flush) | (underflow_q & ~clr_err);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      af_q        <= 1'b0;
      ae_q        <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      dout_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      af_q        <= af_d;
      ae_q        <= ae_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      dout_q      <= dout_d;
    end
  end

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk   (sys_clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (din),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (ram_rdata)
  );

  // FWFT shows the head word directly; an empty FIFO presents zero.
  if (FWFT == MODE_FWFT) begin : g_fwft
    assign dout = empty_q ? '0 : ram_rdata;
  end else begin : g_std
    assign dout = dout_q;
  end

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: standard and FWFT instances share stimulus and
// are compared each cycle against a queue-based reference of the FIFO.
module tb_sync_fifo_param;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       flush = 1'b0, clr_err = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [7:0] din = '0;

  logic [7:0] s_dout, f_dout;
  logic       s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic       f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [4:0] s_count, f_count;

  always #5 sys_clk = ~sys_clk;

  sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) dut_std (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .flush(flush), .clr_err(clr_err),
    .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(s_dout), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_count), .overflow(s_ovf), .underflow(s_udf));

  sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1)) dut_fwft (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .flush(flush), .clr_err(clr_err),
    .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(f_dout), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_udf));

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] mq[$];
  logic       m_ovf = 1'b0, m_udf = 1'b0;
  logic [7:0] m_dstd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    m_dstd = '0;
  endtask

  task automatic model_update(input logic w, input logic [7:0] d, input logic r,
                              input logic f, input logic c);
    int  sz;
    logic ov_ev, uf_ev;
    sz    = mq.size();
    ov_ev = 1'b0;
    uf_ev = 1'b0;
    if (f) begin
      mq.delete();
    end else begin
      ov_ev = w && (sz == 16);
      uf_ev = r && (sz == 0);
      if (r && sz > 0) m_dstd = mq.pop_front();
      if (w && sz < 16) mq.push_back(d);
    end
    m_ovf = ov_ev | (m_ovf & ~c);
    m_udf = uf_ev | (m_udf & ~c);
  endtask

  task automatic check_all();
    int sz;
    logic [7:0] exp_fw;
    sz     = mq.size();
    exp_fw = (sz > 0) ? mq[0] : 8'h00;
    chk("std_count", 32'(s_count), 32'(sz));
    chk("std_full",  32'(s_full),  32'(sz == 16));
    chk("std_empty", 32'(s_empty), 32'(sz == 0));
    chk("std_af",    32'(s_af),    32'(sz >= 14));
    chk("std_ae",    32'(s_ae),    32'(sz <= 2));
    chk("std_ovf",   32'(s_ovf),   32'(m_ovf));
    chk("std_udf",   32'(s_udf),   32'(m_udf));
    chk("std_dout",  32'(s_dout),  32'(m_dstd));
    chk("fw_count",  32'(f_count), 32'(sz));
    chk("fw_full",   32'(f_full),  32'(sz == 16));
    chk("fw_empty",  32'(f_empty), 32'(sz == 0));
    chk("fw_af",     32'(f_af),    32'(sz >= 14));
    chk("fw_ae",     32'(f_ae),    32'(sz <= 2));
    chk("fw_ovf",    32'(f_ovf),   32'(m_ovf));
    chk("fw_udf",    32'(f_udf),   32'(m_udf));
    chk("fw_dout",   32'(f_dout),  32'(exp_fw));
  endtask

  // Drive one cycle of stimulus, advance the model at the edge, compare 1ns later.
  task automatic step(input logic w, input logic [7:0] d, input logic r,
                      input logic f, input logic c);
    wr_en = w; din = d; rd_en = r; flush = f; clr_err = c;
    @(posedge sys_clk);
    model_update(w, d, r, f, c);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
    check_all();
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] din;
    logic       rd;
    logic       fl;
    logic       clr;
    int         exp_count;
    logic       exp_empty;
    logic       exp_udf;
    logic [7:0] exp_dstd;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 8'h00};
    vecs[1] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0, 8'h00};
    vecs[2] = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0, 8'h11};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 8'h22};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 8'h33};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1, 8'h33};
    vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0, 8'h33};
    vecs[7] = '{1'b1, 8'h44, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b1, 8'h33};
    vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b0, 8'h44};

    // Reset state
    model_reset();
    repeat (2) @(posedge sys_clk);
    #1;
    check_all();
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
    check_all();

    // Hand-computed vectors
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].wr, vecs[i].din, vecs[i].rd, vecs[i].fl, vecs[i].clr);
      chk($sformatf("vec%0d_count", i), 32'(s_count), 32'(vecs[i].exp_count));
      chk($sformatf("vec%0d_empty", i), 32'(f_empty), 32'(vecs[i].exp_empty));
      chk($sformatf("vec%0d_udf", i),   32'(s_udf),   32'(vecs[i].exp_udf));
      chk($sformatf("vec%0d_dstd", i),  32'(s_dout),  32'(vecs[i].exp_dstd));
    end

    // Fill 0x01..0x10, almost_full from 14
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      chk("fill_af", 32'(s_af), 32'(i >= 14));
    end
    chk("fill_full", 32'(f_full), 32'd1);
    chk("fill_count", 32'(f_count), 32'd16);

    // Overflow on full, then clear
    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    chk("ovf_set", 32'(s_ovf), 32'd1);
    chk("ovf_count", 32'(s_count), 32'd16);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("ovf_clr", 32'(f_ovf), 32'd0);

    // Drain in order
    for (int i = 1; i <= 16; i++) begin
      chk("drain_fwft", 32'(f_dout), 32'(i));
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("drain_std", 32'(s_dout), 32'(i));
    end
    chk("drain_empty", 32'(s_empty), 32'd1);

    // Underflow, then write+read on empty
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("udf_set", 32'(s_udf), 32'd1);
    chk("udf_dout_hold", 32'(s_dout), 32'h10);
    step(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
    chk("udf_wr_count", 32'(s_count), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

    // Count 8, 20 cycles of simultaneous read and write
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'(8'h80 + i), 1'b1, 1'b0, 1'b0);
      chk("steady_count", 32'(f_count), 32'd8);
    end
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("steady_last", 32'(s_dout), 32'h93);

    // Count 10, flush with a concurrent write
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
    chk("flush_count", 32'(s_count), 32'd0);
    chk("flush_empty", 32'(f_empty), 32'd1);
    step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    chk("flush_next", 32'(f_dout), 32'h3C);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Async reset mid-burst at count 5
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 1'b0);
    wr_en = 1'b1; din = 8'hFF;
    #2;
    sys_rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    wr_en = 1'b0;
    @(posedge sys_clk);
    #1;
    check_all();
    sys_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h70 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("post_rst_dout", 32'(s_dout), 32'h72);

    // Random traffic against the reference queue
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 15) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
